// File: rtl/keccak_lane_loader.sv
// Loads 25 Keccak lanes, hands the 1600-bit state to a permutation core and buffers its result.
// Optional macro KECCAK_LOADER_CHAIN_EN feeds each result back into the state for back-to-back starts.
module keccak_lane_loader #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [4:0]       wr_idx_i,
  input  logic [31:0]      wr_lo_i,
  input  logic [31:0]      wr_hi_i,
  input  logic             start_req_i,
  output logic             start_err_o,
  output logic             wr_err_o,
  output logic             perm_start_o,
  output logic [1599:0]    perm_din_o,
  input  logic [1599:0]    perm_dout_i,
  input  logic             perm_done_i,
  input  logic             clear_i,
  input  logic [5:0]       rd_idx_i,
  output logic [31:0]      rd_data_o,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic             lanes_full_o,
  output logic [CNT_W-1:0] perm_cycles_o
);

  typedef enum logic [1:0] {IDLE, FIRE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [1599:0]     lanes_q, result_q;
  logic [24:0]       mask_q;
  logic [CNT_W-1:0]  cycles_q;
  logic              result_valid_q, start_err_q, wr_err_q;
  logic [31:0]       rd_data_q, rd_word;
  logic              wr_fire, idx_ok, lanes_full;
  logic              go_fire, start_rej, do_clear, capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign lanes_full = &mask_q;
  assign wr_ready_o = (state_q == IDLE) && !start_req_i;
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign idx_ok     = (wr_idx_i < 5'd25);

  // Clear outranks start; a start only fires once every lane has been written.
  always_comb begin
    state_d   = state_q;
    go_fire   = 1'b0;
    start_rej = 1'b0;
    do_clear  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          do_clear = 1'b1;
        end else if (start_req_i) begin
          if (lanes_full) begin
            state_d = FIRE;
            go_fire = 1'b1;
          end else begin
            start_rej = 1'b1;
          end
        end
      end
      FIRE: state_d = BUSY;
      BUSY: begin
        if (perm_done_i) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_word = 32'd0;
    for (int k = 0; k < 50; k++) begin
      if (rd_idx_i == 6'(k)) rd_word = result_q[32*k +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      cycles_q       <= '0;
      result_valid_q <= 1'b0;
      start_err_q    <= 1'b0;
      wr_err_q       <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_err_q <= start_rej;
      wr_err_q    <= wr_fire && !idx_ok;
      rd_data_q   <= rd_word;
      if (do_clear) begin
        mask_q <= '0;
`ifndef KECCAK_LOADER_CHAIN_EN
      end else if (go_fire) begin
        mask_q <= '0;
`endif
      end else if (wr_fire && idx_ok) begin
        mask_q <= mask_q | (25'd1 << wr_idx_i);
      end
      if (go_fire) cycles_q <= '0;
      else if (state_q == BUSY) cycles_q <= sat_inc(cycles_q);
      if (do_clear || go_fire) result_valid_q <= 1'b0;
      else if (capture) result_valid_q <= 1'b1;
    end
  end

  // Lane and result storage; only the write port (and chained done) modify the lanes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lanes_q  <= '0;
      result_q <= '0;
    end else begin
      for (int i = 0; i < 25; i++) begin
        if (wr_fire && wr_idx_i == 5'(i)) lanes_q[64*i +: 64] <= {wr_hi_i, wr_lo_i};
      end
`ifdef KECCAK_LOADER_CHAIN_EN
      if (capture) lanes_q <= perm_dout_i;
`endif
      if (capture) result_q <= perm_dout_i;
    end
  end

  assign perm_start_o   = (state_q == FIRE);
  assign busy_o         = (state_q != IDLE);
  assign perm_din_o     = lanes_q;
  assign lanes_full_o   = lanes_full;
  assign perm_cycles_o  = cycles_q;
  assign result_valid_o = result_valid_q;
  assign start_err_o    = start_err_q;
  assign wr_err_o       = wr_err_q;
  assign rd_data_o      = rd_data_q;

endmodule

// File: tb/tb_keccak_lane_loader.sv
// Self-checking bench for keccak_lane_loader; read results are tracked through a scoreboard queue.
// Covers both builds of KECCAK_LOADER_CHAIN_EN.
module tb_keccak_lane_loader;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             wr_valid, wr_ready;
  logic [4:0]       wr_idx;
  logic [31:0]      wr_lo, wr_hi;
  logic             start_req, start_err, wr_err, perm_start;
  logic [1599:0]    perm_din, perm_dout;
  logic             perm_done, clear;
  logic [5:0]       rd_idx;
  logic [31:0]      rd_data;
  logic             busy, result_valid, lanes_full;
  logic [CNT_W-1:0] perm_cycles;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  keccak_lane_loader #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_idx_i(wr_idx),
    .wr_lo_i(wr_lo), .wr_hi_i(wr_hi),
    .start_req_i(start_req), .start_err_o(start_err), .wr_err_o(wr_err),
    .perm_start_o(perm_start), .perm_din_o(perm_din), .perm_dout_i(perm_dout),
    .perm_done_i(perm_done), .clear_i(clear),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data),
    .busy_o(busy), .result_valid_o(result_valid), .lanes_full_o(lanes_full),
    .perm_cycles_o(perm_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_lane(input int idx, input logic [31:0] lo, input logic [31:0] hi);
    wr_valid = 1'b1;
    wr_idx   = 5'(idx);
    wr_lo    = lo;
    wr_hi    = hi;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) wr_lane(i, 32'(i), ~32'(i));
  endtask

  task automatic rd_word(input int k, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    rd_idx = 6'(k);
    rd_q.push_back('{tag, exp});
    @(negedge clk);
    e = rd_q.pop_front();
    check(e.tag, 64'(rd_data), 64'(e.exp));
  endtask

  initial begin
    wr_valid = 1'b0; wr_idx = '0; wr_lo = '0; wr_hi = '0;
    start_req = 1'b0; perm_done = 1'b0; clear = 1'b0; rd_idx = '0;
    perm_dout = '0;
    for (int k = 0; k < 50; k++) perm_dout[32*k +: 32] = 32'hA500_0000 | 32'(k);
    perm_dout[32*7 +: 32] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    check("rst_in_busy", 64'(busy), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_lanes_full", 64'(lanes_full), 64'd0);
    check("rst_cycles", 64'(perm_cycles), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_perm_start", 64'(perm_start), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_din_lane0", perm_din[63:0], 64'd0);

    // Partial load: start must be rejected with a single-cycle error pulse.
    fill(24);
    check("partial_lanes_full", 64'(lanes_full), 64'd0);
    start_req = 1'b1;
    #1 check("start_blocks_wr_ready", 64'(wr_ready), 64'd0);
    @(negedge clk);
    start_req = 1'b0;
    check("rej_start_err", 64'(start_err), 64'd1);
    check("rej_busy", 64'(busy), 64'd0);
    check("rej_perm_start", 64'(perm_start), 64'd0);
    @(negedge clk);
    check("rej_start_err_drop", 64'(start_err), 64'd0);
    check("rej_perm_start2", 64'(perm_start), 64'd0);

    // Out-of-range lane index.
    wr_valid = 1'b1; wr_idx = 5'd25; wr_lo = 32'h1234_5678; wr_hi = 32'h9ABC_DEF0;
    #1 check("idx25_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("idx25_wr_err", 64'(wr_err), 64'd1);
    check("idx25_mask", 64'(lanes_full), 64'd0);
    @(negedge clk);
    check("idx25_wr_err_drop", 64'(wr_err), 64'd0);

    wr_lane(24, 32'd24, ~32'd24);
    check("full_lanes_full", 64'(lanes_full), 64'd1);
    check("din_lane0", perm_din[63:0], 64'hFFFF_FFFF_0000_0000);
    check("din_lane24", perm_din[1599:1536], {~32'd24, 32'd24});

    start_req = 1'b1;
    @(negedge clk);
    check("fire_perm_start", 64'(perm_start), 64'd1);
    check("fire_busy", 64'(busy), 64'd1);
    check("fire_start_err", 64'(start_err), 64'd0);
    check("fire_cycles", 64'(perm_cycles), 64'd0);
`ifdef KECCAK_LOADER_CHAIN_EN
    check("fire_mask_kept", 64'(lanes_full), 64'd1);
`else
    check("fire_mask_cleared", 64'(lanes_full), 64'd0);
`endif
    @(negedge clk);
    start_req = 1'b0;
    check("busy_perm_start_low", 64'(perm_start), 64'd0);
    check("busy_busy", 64'(busy), 64'd1);
    check("busy_no_start_err", 64'(start_err), 64'd0);
    repeat (29) @(negedge clk);
    check("busy_cycles29", 64'(perm_cycles), 64'd29);
    perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
    check("done_cycles30", 64'(perm_cycles), 64'd30);
    check("done_result_valid", 64'(result_valid), 64'd1);
    check("done_busy", 64'(busy), 64'd0);

    rd_word(7, 32'hDEAD_BEEF, "rd_w7");
    rd_word(0, 32'hA500_0000, "rd_w0");
    rd_word(49, 32'hA500_0031, "rd_w49");
    rd_word(50, 32'd0, "rd_w50");
    rd_word(63, 32'd0, "rd_w63");

`ifdef KECCAK_LOADER_CHAIN_EN
    check("chain_lanes_full", 64'(lanes_full), 64'd1);
    check("chain_din_w7", 64'(perm_din[255:224]), 64'hDEAD_BEEF);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    check("chain_perm_start", 64'(perm_start), 64'd1);
    check("chain_no_err", 64'(start_err), 64'd0);
    @(negedge clk);
    perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
    check("chain_done_valid", 64'(result_valid), 64'd1);
    check("chain_done_busy", 64'(busy), 64'd0);
`else
    check("nochain_lanes_full", 64'(lanes_full), 64'd0);
    check("nochain_din_w7", 64'(perm_din[255:224]), 64'hFFFF_FFFC);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    check("nochain_start_err", 64'(start_err), 64'd1);
    check("nochain_busy", 64'(busy), 64'd0);
`endif

    // Clear together with start: clear wins, nothing fires, no error.
    fill(25);
    check("reload_full", 64'(lanes_full), 64'd1);
    clear = 1'b1; start_req = 1'b1;
    @(negedge clk);
    clear = 1'b0; start_req = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_start_err", 64'(start_err), 64'd0);
    check("clr_perm_start", 64'(perm_start), 64'd0);
    check("clr_lanes_full", 64'(lanes_full), 64'd0);
    check("clr_result_valid", 64'(result_valid), 64'd0);

    // Asynchronous reset in the middle of a permutation.
    fill(25);
    rd_idx = 6'd7;
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
    rst_ni = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rd_data", 64'(rd_data), 64'd0);
    check("arst_cycles", 64'(perm_cycles), 64'd0);
    check("arst_lanes_full", 64'(lanes_full), 64'd0);
    check("arst_din_lane24", perm_din[1599:1536], 64'd0);
    check("arst_perm_start", 64'(perm_start), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
    check("post_rst_result_valid", 64'(result_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    check("post_rst_result_valid2", 64'(result_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
